// File: rtl/vmem_pkg.sv
// Shared types and sizes for the video object memory arbiter.
package vmem_pkg;

  localparam int OBJ_ADDR_W = 5;
  localparam int OBJ_DATA_W = 144;

  typedef enum logic {
    REQ_MATRIX = 1'b0,
    REQ_CLIP   = 1'b1
  } req_id_t;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/vmem_arbiter_if.sv
// Bundle of the matrix port, clipper port and object RAM port.
// "slave" is the arbiter side, "master" is the requester/RAM side.
interface vmem_arbiter_if
  import vmem_pkg::*;
#(
  parameter int ADDR_W = OBJ_ADDR_W,
  parameter int DATA_W = OBJ_DATA_W
);

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_wr_blocked;

  logic              c_req;
  logic [ADDR_W-1:0] c_addr;
  logic              c_lock;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              lock_timeout;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    input  c_req, c_addr, c_lock,
    input  ram_rdata,
    output m_gnt, m_rvalid, m_rdata, m_wr_blocked,
    output c_gnt, c_rvalid, c_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output lock_timeout
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    output c_req, c_addr, c_lock,
    output ram_rdata,
    input  m_gnt, m_rvalid, m_rdata, m_wr_blocked,
    input  c_gnt, c_rvalid, c_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  lock_timeout
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On a tie the requester that did not win
// last time is chosen; the last-winner register tracks every grant.
module rr_arb2
  import vmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  output logic       win_valid,
  output req_id_t    win_id
);

  req_id_t last_win;

  // Pick a winner from the eligible set this cycle
  always_comb begin
    win_valid = |elig;
    win_id    = REQ_MATRIX;
    case (elig)
      2'b01:   win_id = REQ_MATRIX;
      2'b10:   win_id = REQ_CLIP;
      2'b11:   win_id = (last_win == REQ_MATRIX) ? REQ_CLIP : REQ_MATRIX;
      default: win_id = REQ_MATRIX;
    endcase
  end

  // Remember who won so the other side gets the next tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win <= REQ_MATRIX;
    end else if (win_valid) begin
      last_win <= win_id;
    end
  end

endmodule

// File: rtl/vmem_arbiter.sv
// Serialises matrix (read/write) and clipper (read-only) accesses onto the
// single-port object RAM. Matrix writes are held off while the clipper has
// a frame lock; a sticky flag reports a write that waited too long.
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int ADDR_W   = OBJ_ADDR_W,
  parameter int DATA_W   = OBJ_DATA_W,
  parameter int MAX_LOCK = 4096
)(
  input  logic            clk,
  input  logic            rst_n,
  vmem_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  lock_state_t       lock_state;
  logic              m_wr_blocked;
  logic              m_elig;
  logic              c_elig;
  logic              win_valid;
  req_id_t           win_id;

  logic              gnt_m_q;
  logic              gnt_c_q;
  logic              en_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              rsp_valid_q;
  req_id_t           rsp_id_q;
  logic              m_rvalid;
  logic              c_rvalid;

  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout_q;

  // A write is held off only by the registered lock state, so a lock that
  // rises this cycle does not affect a decision made this cycle.
  assign m_wr_blocked = (lock_state == LOCKED) & bus.m_req & bus.m_we;

  // The grant cycle is skipped so a still-asserted request is not granted twice
  assign m_elig = bus.m_req & ~gnt_m_q & ~m_wr_blocked;
  assign c_elig = bus.c_req & ~gnt_c_q;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .elig      ({c_elig, m_elig}),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  // Frame lock follows c_lock with one cycle of delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= OPEN;
    end else begin
      case (lock_state)
        OPEN:    if (bus.c_lock)  lock_state <= LOCKED;
        LOCKED:  if (!bus.c_lock) lock_state <= OPEN;
        default: lock_state <= OPEN;
      endcase
    end
  end

  // Register the winning access onto the RAM port and pulse its grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_m_q <= 1'b0;
      gnt_c_q <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      gnt_m_q <= win_valid & (win_id == REQ_MATRIX);
      gnt_c_q <= win_valid & (win_id == REQ_CLIP);
      en_q    <= win_valid;
      we_q    <= win_valid & (win_id == REQ_MATRIX) & bus.m_we;
      if (win_valid) begin
        addr_q  <= (win_id == REQ_MATRIX) ? bus.m_addr : bus.c_addr;
        wdata_q <= (win_id == REQ_MATRIX) ? bus.m_wdata : '0;
      end
    end
  end

  // Tag each issued read with its owner so the response is steered back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ_MATRIX;
    end else begin
      rsp_valid_q <= en_q & ~we_q;
      rsp_id_q    <= gnt_c_q ? REQ_CLIP : REQ_MATRIX;
    end
  end

  // Count blocked-write cycles; saturate and latch the timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!m_wr_blocked) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CNT_W'(MAX_LOCK)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (m_wr_blocked && (wait_cnt == CNT_W'(MAX_LOCK - 1))) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign m_rvalid = rsp_valid_q & (rsp_id_q == REQ_MATRIX);
  assign c_rvalid = rsp_valid_q & (rsp_id_q == REQ_CLIP);

  assign bus.m_gnt        = gnt_m_q;
  assign bus.c_gnt        = gnt_c_q;
  assign bus.m_rvalid     = m_rvalid;
  assign bus.c_rvalid     = c_rvalid;
  assign bus.m_rdata      = m_rvalid ? bus.ram_rdata : {DATA_W{1'b0}};
  assign bus.c_rdata      = c_rvalid ? bus.ram_rdata : {DATA_W{1'b0}};
  assign bus.m_wr_blocked = m_wr_blocked;
  assign bus.ram_en       = en_q;
  assign bus.ram_we       = we_q;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_wdata    = wdata_q;
  assign bus.lock_timeout = timeout_q;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: per-cycle vector table plus hand-written
// sequences for write/read ordering, lock timeout and mid-access reset.
module tb_vmem_arbiter;

  localparam int AW = 5;
  localparam int DW = 144;

  typedef struct {
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          c_req;
    logic [AW-1:0] c_addr;
    logic          c_lock;
    logic          e_m_gnt;
    logic          e_c_gnt;
    logic          e_ram_en;
    logic          e_ram_we;
    logic [AW-1:0] e_ram_addr;
    logic          e_m_rvalid;
    logic [AW-1:0] e_m_raddr;
    logic          e_c_rvalid;
    logic [AW-1:0] e_c_raddr;
    logic          e_blk;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  logic [DW-1:0] mem [32];
  logic [DW-1:0] ram_q;
  logic          m_pend;
  logic          c_pend;

  localparam logic [DW-1:0] W5 = {9{16'hC0DE}};
  localparam logic [DW-1:0] DA = {9{16'hA11A}};
  localparam logic [DW-1:0] DB = {9{16'hB22B}};

  vmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    pat = {9{11'h5A3, a}};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Object RAM model: synchronous read, data valid the cycle after ram_en
  initial begin
    ram_q = '0;
    for (int i = 0; i < 32; i++) mem[i] = pat(AW'(i));
  end

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      ram_q <= mem[bus.ram_addr];
    end
  end

  assign bus.ram_rdata = ram_q;

  // Requesters must hold req until their grant
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      c_pend <= 1'b0;
    end else begin
      if (m_pend) assert (bus.m_req) else $error("[TB] protocol: m_req dropped before m_gnt");
      if (c_pend) assert (bus.c_req) else $error("[TB] protocol: c_req dropped before c_gnt");
      m_pend <= bus.m_req && !bus.m_gnt;
      c_pend <= bus.c_req && !bus.c_gnt;
    end
  end

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_data(name, {{(DW-1){1'b0}}, act}, {{(DW-1){1'b0}}, exp});
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, " m_gnt"}, bus.m_gnt, 1'b0);
    check_bit({tag, " c_gnt"}, bus.c_gnt, 1'b0);
    check_bit({tag, " m_rvalid"}, bus.m_rvalid, 1'b0);
    check_bit({tag, " c_rvalid"}, bus.c_rvalid, 1'b0);
    check_bit({tag, " ram_en"}, bus.ram_en, 1'b0);
    check_bit({tag, " ram_we"}, bus.ram_we, 1'b0);
    check_data({tag, " ram_addr"}, DW'(bus.ram_addr), '0);
    check_data({tag, " ram_wdata"}, bus.ram_wdata, '0);
    check_data({tag, " m_rdata"}, bus.m_rdata, '0);
    check_data({tag, " c_rdata"}, bus.c_rdata, '0);
    check_bit({tag, " m_wr_blocked"}, bus.m_wr_blocked, 1'b0);
    check_bit({tag, " lock_timeout"}, bus.lock_timeout, 1'b0);
  endtask

  task automatic add_vec(
    input logic mr, input logic mw, input logic [AW-1:0] ma, input logic [DW-1:0] md,
    input logic cr, input logic [AW-1:0] ca, input logic cl,
    input logic emg, input logic ecg, input logic een, input logic ewe, input logic [AW-1:0] ead,
    input logic emv, input logic [AW-1:0] emra, input logic ecv, input logic [AW-1:0] ecra,
    input logic eblk);
    vec_t v;
    v.m_req = mr; v.m_we = mw; v.m_addr = ma; v.m_wdata = md;
    v.c_req = cr; v.c_addr = ca; v.c_lock = cl;
    v.e_m_gnt = emg; v.e_c_gnt = ecg; v.e_ram_en = een; v.e_ram_we = ewe; v.e_ram_addr = ead;
    v.e_m_rvalid = emv; v.e_m_raddr = emra; v.e_c_rvalid = ecv; v.e_c_raddr = ecra;
    v.e_blk = eblk;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.m_req   = v.m_req;
    bus.m_we    = v.m_we;
    bus.m_addr  = v.m_addr;
    bus.m_wdata = v.m_wdata;
    bus.c_req   = v.c_req;
    bus.c_addr  = v.c_addr;
    bus.c_lock  = v.c_lock;
  endtask

  task automatic check_output(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    check_bit({t, " m_gnt"}, bus.m_gnt, v.e_m_gnt);
    check_bit({t, " c_gnt"}, bus.c_gnt, v.e_c_gnt);
    check_bit({t, " ram_en"}, bus.ram_en, v.e_ram_en);
    check_bit({t, " ram_we"}, bus.ram_we, v.e_ram_we);
    if (v.e_ram_en) check_data({t, " ram_addr"}, DW'(bus.ram_addr), DW'(v.e_ram_addr));
    if (v.e_ram_we) check_data({t, " ram_wdata"}, bus.ram_wdata, v.m_wdata);
    check_bit({t, " m_rvalid"}, bus.m_rvalid, v.e_m_rvalid);
    check_bit({t, " c_rvalid"}, bus.c_rvalid, v.e_c_rvalid);
    check_data({t, " m_rdata"}, bus.m_rdata, v.e_m_rvalid ? pat(v.e_m_raddr) : '0);
    check_data({t, " c_rdata"}, bus.c_rdata, v.e_c_rvalid ? pat(v.e_c_raddr) : '0);
    check_bit({t, " m_wr_blocked"}, bus.m_wr_blocked, v.e_blk);
    check_bit({t, " lock_timeout"}, bus.lock_timeout, 1'b0);
  endtask

  // Bound the whole run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic got;
    int   cyc;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.m_req = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.c_req = 1'b0; bus.c_addr = '0; bus.c_lock = 1'b0;

    // Single matrix read, then alternating contention, then lock handling
    //       mr mw ma  md  cr ca  cl | mg cg en we ad | mv ma  cv ca  blk
    add_vec(1, 0, 3,  '0, 0, 0,  0,   0, 0, 0, 0, 0,   0, 0,  0, 0,  0);
    add_vec(1, 0, 3,  '0, 0, 0,  0,   1, 0, 1, 0, 3,   0, 0,  0, 0,  0);
    add_vec(0, 0, 0,  '0, 0, 0,  0,   0, 0, 0, 0, 0,   1, 3,  0, 0,  0);
    add_vec(0, 0, 0,  '0, 0, 0,  0,   0, 0, 0, 0, 0,   0, 0,  0, 0,  0);
    add_vec(1, 0, 10, '0, 1, 20, 0,   0, 0, 0, 0, 0,   0, 0,  0, 0,  0);
    add_vec(1, 0, 10, '0, 1, 20, 0,   0, 1, 1, 0, 20,  0, 0,  0, 0,  0);
    add_vec(1, 0, 10, '0, 1, 21, 0,   1, 0, 1, 0, 10,  0, 0,  1, 20, 0);
    add_vec(1, 0, 11, '0, 1, 21, 0,   0, 1, 1, 0, 21,  1, 10, 0, 0,  0);
    add_vec(1, 0, 11, '0, 0, 0,  0,   1, 0, 1, 0, 11,  0, 0,  1, 21, 0);
    add_vec(0, 0, 0,  '0, 0, 0,  0,   0, 0, 0, 0, 0,   1, 11, 0, 0,  0);
    add_vec(0, 0, 0,  '0, 0, 0,  1,   0, 0, 0, 0, 0,   0, 0,  0, 0,  0);
    add_vec(1, 1, 5,  W5, 0, 0,  1,   0, 0, 0, 0, 0,   0, 0,  0, 0,  1);
    add_vec(1, 1, 5,  W5, 1, 2,  1,   0, 0, 0, 0, 0,   0, 0,  0, 0,  1);
    add_vec(1, 1, 5,  W5, 1, 2,  1,   0, 1, 1, 0, 2,   0, 0,  0, 0,  1);
    add_vec(1, 1, 5,  W5, 0, 0,  1,   0, 0, 0, 0, 0,   0, 0,  1, 2,  1);
    add_vec(1, 1, 5,  W5, 0, 0,  0,   0, 0, 0, 0, 0,   0, 0,  0, 0,  1);
    add_vec(1, 1, 5,  W5, 0, 0,  0,   0, 0, 0, 0, 0,   0, 0,  0, 0,  0);
    add_vec(1, 1, 5,  W5, 0, 0,  0,   1, 0, 1, 1, 5,   0, 0,  0, 0,  0);
    add_vec(0, 0, 0,  '0, 0, 0,  0,   0, 0, 0, 0, 0,   0, 0,  0, 0,  0);

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      check_output(i, vecs[i]);
    end

    // Write then read of the same address returns the new data
    @(negedge clk);
    bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_addr = 5'd7; bus.m_wdata = DA;
    @(negedge clk); #1;
    check_bit("wr7 m_gnt", bus.m_gnt, 1'b1);
    check_bit("wr7 ram_we", bus.ram_we, 1'b1);
    check_data("wr7 ram_addr", DW'(bus.ram_addr), DW'(7));
    check_data("wr7 ram_wdata", bus.ram_wdata, DA);
    @(negedge clk);
    bus.m_req = 1'b0; bus.m_we = 1'b0;
    bus.c_req = 1'b1; bus.c_addr = 5'd7;
    @(negedge clk); #1;
    check_bit("rd7 c_gnt", bus.c_gnt, 1'b1);
    check_bit("rd7 ram_we", bus.ram_we, 1'b0);
    @(negedge clk);
    bus.c_req = 1'b0;
    #1;
    check_bit("rd7 c_rvalid", bus.c_rvalid, 1'b1);
    check_data("rd7 c_rdata", bus.c_rdata, DA);
    check_bit("rd7 m_rvalid", bus.m_rvalid, 1'b0);

    // Held write under lock: flag sets after 16 blocked cycles and sticks
    @(negedge clk);
    bus.c_lock = 1'b1;
    @(negedge clk);
    bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_addr = 5'd9; bus.m_wdata = DB;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (k == 15) check_bit("to k15 lock_timeout", bus.lock_timeout, 1'b0);
      if (k == 16) check_bit("to k16 lock_timeout", bus.lock_timeout, 1'b1);
      if (k == 20) begin
        check_bit("to k20 m_gnt", bus.m_gnt, 1'b0);
        check_bit("to k20 m_wr_blocked", bus.m_wr_blocked, 1'b1);
        check_bit("to k20 lock_timeout", bus.lock_timeout, 1'b1);
      end
    end
    bus.c_lock = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 6) begin
      @(negedge clk); #1;
      cyc++;
      if (bus.m_gnt) got = 1'b1;
    end
    check_bit("unlock m_gnt seen", got, 1'b1);
    check_data("unlock gnt cycles", DW'(cyc), DW'(2));
    check_bit("unlock ram_we", bus.ram_we, 1'b1);
    check_data("unlock ram_addr", DW'(bus.ram_addr), DW'(9));
    check_data("unlock ram_wdata", bus.ram_wdata, DB);
    check_bit("unlock lock_timeout", bus.lock_timeout, 1'b1);
    @(negedge clk);
    bus.m_req = 1'b0; bus.m_we = 1'b0;
    #1;
    check_bit("after lock_timeout", bus.lock_timeout, 1'b1);

    // Reset between a read grant and its response
    @(negedge clk);
    bus.m_req = 1'b1; bus.m_addr = 5'd4;
    @(negedge clk); #1;
    check_bit("rst m_gnt", bus.m_gnt, 1'b1);
    rst_n = 1'b0;
    bus.m_req = 1'b0;
    #1;
    check_all_zero("rst now");
    @(negedge clk); #1;
    check_all_zero("rst +1");
    @(negedge clk); #1;
    check_all_zero("rst +2");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("rst rel");
    @(negedge clk); #1;
    check_all_zero("rst rel+1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
